change_dispense_ctrl: RTL and testbench

Sequences the change-return hopper after a sale or cancel. It takes a change amount from the main vending FSM and dispenses coins greedily (largest denomination first). Each coin is issued over a req/ack handshake with the hopper driver. Per-denomination stock is tracked so empty tubes are skipped, and the block reports done or fail with the residual amount.

---
 rtl/vm_pkg.sv | 38 +++
 rtl/coin_select.sv | 24 ++
 rtl/change_dispense_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_change_dispense_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vm_pkg.sv
// Shared constants and types for the change-return hopper sequencer.
package vm_pkg;

  localparam int unsigned N_DEN   = 5;
  localparam int unsigned STOCK_W = 4;

  localparam logic [2:0] DEN_50 = 3'd0;
  localparam logic [2:0] DEN_20 = 3'd1;
  localparam logic [2:0] DEN_10 = 3'd2;
  localparam logic [2:0] DEN_5  = 3'd3;
  localparam logic [2:0] DEN_1  = 3'd4;

  typedef logic [7:0]         amt_t;
  typedef logic [STOCK_W-1:0] stock_t;

  // One-hot to match the existing vending FSM style.
  typedef enum logic [5:0] {
    ST_IDLE    = 6'b000001,
    ST_SELECT  = 6'b000010,
    ST_REQ     = 6'b000100,
    ST_RELEASE = 6'b001000,
    ST_DONE    = 6'b010000,
    ST_FAIL    = 6'b100000
  } state_e;

  // Face value of each tube, largest first.
  function automatic amt_t coin_value(input logic [2:0] idx);
    case (idx)
      DEN_50:  coin_value = 8'd50;
      DEN_20:  coin_value = 8'd20;
      DEN_10:  coin_value = 8'd10;
      DEN_5:   coin_value = 8'd5;
      DEN_1:   coin_value = 8'd1;
      default: coin_value = 8'd0;
    endcase
  endfunction

endpackage

// File: rtl/coin_select.sv
// Greedy picker: largest denomination that fits the remaining amount and
// whose tube is not empty.
module coin_select
  import vm_pkg::*;
(
  input  amt_t                            remain_i,
  input  logic [N_DEN-1:0][STOCK_W-1:0]  stock_i,
  output logic                            valid_o,
  output logic [2:0]                      idx_o
);

  // Lowest index (largest value) wins; later matches are ignored once valid.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int unsigned i = 0; i < N_DEN; i++) begin
      if (!valid_o && (coin_value(i[2:0]) <= remain_i) && (stock_i[i[2:0]] != '0)) begin
        valid_o = 1'b1;
        idx_o   = i[2:0];
      end
    end
  end

endmodule

// File: rtl/change_dispense_ctrl.sv
// Change-return sequencer: pays out an amount coin by coin over a 4-phase
// req/ack handshake with the hopper, tracking per-tube stock.
module change_dispense_ctrl
  import vm_pkg::*;
#(
  parameter logic [3:0]  INIT_STOCK     = 4'd10,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd1_000_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       start,
  input  logic [7:0] change_amt,
  input  logic       abort,
  output logic       coin_req,
  output logic [2:0] coin_sel,
  input  logic       coin_ack,
  input  logic       refill,
  input  logic [2:0] refill_sel,
  output logic       busy,
  output logic       done,
  output logic       fail,
  output logic [7:0] remain
);

  localparam logic [23:0] TIMEOUT_LAST = TIMEOUT_CYCLES - 24'd1;

  state_e                         state_q, state_d;
  amt_t                           remain_q, remain_d;
  logic [2:0]                     coin_sel_q, coin_sel_d;
  logic                           coin_req_q, coin_req_d;
  logic                           busy_q, busy_d;
  logic                           done_q, done_d;
  logic                           fail_q, fail_d;
  logic                           abort_q, abort_d;
  logic [23:0]                    timer_q, timer_d;
  logic [N_DEN-1:0][STOCK_W-1:0]  stock_q, stock_d;

  logic       pick_valid;
  logic [2:0] pick_idx;
  logic       dec_en;
  logic       clr_en;
  logic       abort_seen;

  coin_select u_coin_select (
    .remain_i (remain_q),
    .stock_i  (stock_q),
    .valid_o  (pick_valid),
    .idx_o    (pick_idx)
  );

  // State and datapath registers; reset drops coin_req asynchronously.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= ST_IDLE;
      remain_q   <= '0;
      coin_sel_q <= '0;
      coin_req_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fail_q     <= 1'b0;
      abort_q    <= 1'b0;
      timer_q    <= '0;
      stock_q    <= {N_DEN{INIT_STOCK}};
    end else begin
      state_q    <= state_d;
      remain_q   <= remain_d;
      coin_sel_q <= coin_sel_d;
      coin_req_q <= coin_req_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      fail_q     <= fail_d;
      abort_q    <= abort_d;
      timer_q    <= timer_d;
      stock_q    <= stock_d;
    end
  end

  // Next-state and handshake control; ack beats timeout beats abort in REQ.
  always_comb begin
    state_d    = state_q;
    remain_d   = remain_q;
    coin_sel_d = coin_sel_q;
    coin_req_d = coin_req_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    fail_d     = 1'b0;
    abort_d    = abort_q;
    timer_d    = timer_q;
    dec_en     = 1'b0;
    clr_en     = 1'b0;
    abort_seen = abort_q | abort;

    // Abort is remembered for the whole busy period and acted on at SELECT.
    if ((state_q != ST_IDLE) && abort) begin
      abort_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          remain_d = change_amt;
          busy_d   = 1'b1;
          abort_d  = 1'b0;
          state_d  = ST_SELECT;
        end
      end
      ST_SELECT: begin
        if (remain_q == '0) begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else if (abort_seen || !pick_valid) begin
          fail_d  = 1'b1;
          state_d = ST_FAIL;
        end else begin
          coin_sel_d = pick_idx;
          coin_req_d = 1'b1;
          timer_d    = '0;
          state_d    = ST_REQ;
        end
      end
      ST_REQ: begin
        if (coin_ack) begin
          remain_d   = remain_q - coin_value(coin_sel_q);
          dec_en     = 1'b1;
          coin_req_d = 1'b0;
          state_d    = ST_RELEASE;
        end else if (timer_q == TIMEOUT_LAST) begin
          clr_en     = 1'b1;
          coin_req_d = 1'b0;
          fail_d     = 1'b1;
          state_d    = ST_FAIL;
        end else if (abort_seen) begin
          coin_req_d = 1'b0;
          fail_d     = 1'b1;
          state_d    = ST_FAIL;
        end else begin
          timer_d = timer_q + 24'd1;
        end
      end
      ST_RELEASE: begin
        if (!coin_ack) begin
          state_d = ST_SELECT;
        end
      end
      ST_DONE, ST_FAIL: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Per-tube stock: a jam empties the tube, refill saturates, and a refill
  // landing on the tube being decremented cancels out.
  always_comb begin
    logic hit;
    logic inc;
    stock_d = stock_q;
    hit     = 1'b0;
    inc     = 1'b0;
    for (int unsigned i = 0; i < N_DEN; i++) begin
      hit = (coin_sel_q == i[2:0]);
      inc = refill && (refill_sel == i[2:0]);
      if (clr_en && hit) begin
        stock_d[i[2:0]] = '0;
      end else if (inc && !(dec_en && hit)) begin
        if (stock_q[i[2:0]] != '1) begin
          stock_d[i[2:0]] = stock_q[i[2:0]] + 4'd1;
        end
      end else if (dec_en && hit && !inc) begin
        stock_d[i[2:0]] = stock_q[i[2:0]] - 4'd1;
      end
    end
  end

  assign coin_req = coin_req_q;
  assign coin_sel = coin_sel_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign fail     = fail_q;
  assign remain   = remain_q;

endmodule

// File: tb/tb_change_dispense_ctrl.sv
// Bench for change_dispense_ctrl: a transaction-script model of the payout
// rules predicts every output each cycle, plus directed literal expectations.
module tb_change_dispense_ctrl;

  localparam int TO = 16;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] change_amt = '0;
  logic       abort = 1'b0;
  logic       coin_req;
  logic [2:0] coin_sel;
  logic       coin_ack = 1'b0;
  logic       refill = 1'b0;
  logic [2:0] refill_sel = '0;
  logic       busy, done, fail;
  logic [7:0] remain;

  change_dispense_ctrl #(
    .INIT_STOCK     (4'd10),
    .TIMEOUT_CYCLES (24'd16)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .start      (start),
    .change_amt (change_amt),
    .abort      (abort),
    .coin_req   (coin_req),
    .coin_sel   (coin_sel),
    .coin_ack   (coin_ack),
    .refill     (refill),
    .refill_sel (refill_sel),
    .busy       (busy),
    .done       (done),
    .fail       (fail),
    .remain     (remain)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model state
  int m_stock [5];
  int m_remain;
  bit m_abort;
  bit exp_busy, exp_req, exp_done, exp_fail;
  int exp_sel, exp_remain;
  bit check_en = 1'b0;
  bit rand_en  = 1'b0;

  int coin_log [$];
  int req_run = 0;
  int last_req_run = 0;
  logic req_prev = 1'b0;

  function automatic int val(input int i);
    case (i)
      0: return 50;
      1: return 20;
      2: return 10;
      3: return 5;
      4: return 1;
      default: return 0;
    endcase
  endfunction

  function automatic int greedy(input int rem);
    for (int i = 0; i < 5; i++)
      if (val(i) <= rem && m_stock[i] != 0) return i;
    return -1;
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic check_log(input string name, input int expq [$]);
    chk({name, "_ncoins"}, coin_log.size(), expq.size());
    for (int i = 0; i < expq.size(); i++)
      chk({name, "_coin"}, (i < coin_log.size()) ? coin_log[i] : -1, expq[i]);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 5; i++) m_stock[i] = 10;
    m_remain = 0; m_abort = 0;
    exp_busy = 0; exp_req = 0; exp_done = 0; exp_fail = 0;
    exp_sel = 0; exp_remain = 0;
  endtask

  // Per-cycle compare against the model.
  always @(negedge sys_clk) begin
    if (check_en) begin
      chk("busy",     busy,     exp_busy);
      chk("coin_req", coin_req, exp_req);
      chk("coin_sel", coin_sel, exp_sel);
      chk("done",     done,     exp_done);
      chk("fail",     fail,     exp_fail);
      chk("remain",   remain,   exp_remain);
    end
  end

  // Log of issued coins and length of each request window.
  always @(negedge sys_clk) begin
    if (coin_req && !req_prev) coin_log.push_back(int'(coin_sel));
    if (coin_req) req_run++;
    else if (req_prev) begin
      last_req_run = req_run;
      req_run = 0;
    end
    req_prev = coin_req;
  end

  // Advance one clock and apply the stock effects of this edge to the model.
  task automatic tick(input int dec_i, input int clr_i);
    bit r, ab, inc, d;
    int rs;
    r = refill; rs = int'(refill_sel); ab = abort;
    @(posedge sys_clk);
    if (exp_busy && ab) m_abort = 1;
    for (int i = 0; i < 5; i++) begin
      inc = r && (rs == i);
      d   = (dec_i == i);
      if (clr_i == i) m_stock[i] = 0;
      else if (inc && !d) m_stock[i] = (m_stock[i] == 15) ? 15 : m_stock[i] + 1;
      else if (d && !inc) m_stock[i] = m_stock[i] - 1;
    end
    #1;
    start = 0;
    abort = 0;
    refill = rand_en && ($urandom_range(0, 5) == 0);
    refill_sel = 3'($urandom_range(0, 7));
  endtask

  // Spurious start pulses while busy must be ignored.
  task automatic noise();
    if (rand_en && $urandom_range(0, 7) == 0) begin
      start = 1;
      change_amt = 8'($urandom);
    end
  endtask

  // lat_cfg: >=0 fixed ack latency, -1 random, -2 never ack.
  task automatic txn(input int amt, input int lat_cfg, input int abort_cyc);
    int cyc, pick, n, lat, rl;
    bit ab_now, failed;
    cyc = 0;
    failed = 0;
    start = 1; change_amt = 8'(amt); abort = (abort_cyc == 0);
    m_abort = 0;
    tick(-1, -1); cyc = 1;
    m_remain = amt; exp_busy = 1; exp_remain = amt;
    exp_done = 0; exp_fail = 0; exp_req = 0;
    forever begin
      abort = (cyc == abort_cyc); noise();
      ab_now = m_abort || abort;
      pick = greedy(m_remain);
      tick(-1, -1); cyc++;
      if (m_remain == 0) break;
      if (ab_now || pick < 0) begin failed = 1; break; end
      exp_req = 1; exp_sel = pick;
      if (lat_cfg >= 0) lat = lat_cfg;
      else if (lat_cfg == -2) lat = -1;
      else lat = ($urandom_range(0, 24) == 0) ? -1 : int'($urandom_range(0, 4));
      n = 0;
      forever begin
        abort = (cyc == abort_cyc); noise();
        if (lat >= 0 && n >= lat) begin
          coin_ack = 1;
          tick(pick, -1); cyc++;
          m_remain = m_remain - val(pick);
          exp_remain = m_remain; exp_req = 0;
          break;
        end
        if (n == TO - 1) begin
          tick(-1, pick); cyc++;
          exp_req = 0; failed = 1;
          break;
        end
        if (abort || m_abort) begin
          tick(-1, -1); cyc++;
          exp_req = 0; failed = 1;
          break;
        end
        tick(-1, -1); cyc++; n++;
      end
      if (failed) break;
      rl = (lat_cfg == -1) ? int'($urandom_range(0, 2)) : 0;
      for (int j = 0; ; j++) begin
        coin_ack = (j < rl); abort = (cyc == abort_cyc); noise();
        tick(-1, -1); cyc++;
        if (j >= rl) break;
      end
    end
    if (failed) exp_fail = 1; else exp_done = 1;
    abort = (cyc == abort_cyc); noise();
    tick(-1, -1);
    exp_done = 0; exp_fail = 0; exp_busy = 0;
  endtask

  initial begin
    int pick;
    model_reset();
    // Reset values
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_req", coin_req, 0);
    chk("rst_sel", coin_sel, 0);
    chk("rst_remain", remain, 0);
    chk("rst_done", done, 0);
    chk("rst_fail", fail, 0);
    @(posedge sys_clk); #1;
    sys_rst_n = 1; check_en = 1;
    tick(-1, -1);

    // Test 1: full stocks, 37
    coin_log.delete();
    txn(37, 2, -1);
    check_log("t1", '{1, 2, 3, 4, 4});
    chk("t1_remain", remain, 0);
    chk("t1_model_stock20", m_stock[1], 9);
    chk("t1_model_stock1", m_stock[4], 8);

    // Test 2: empty the 20 tube, then 37
    repeat (9) txn(20, 0, -1);
    chk("t2_model_stock20", m_stock[1], 0);
    coin_log.delete();
    txn(37, 1, -1);
    check_log("t2", '{2, 2, 2, 3, 4, 4});
    chk("t2_remain", remain, 0);

    // Test 3: empty 5 tube, leave two 1s, change 3
    repeat (8) txn(5, 0, -1);
    repeat (4) txn(1, 0, -1);
    chk("t3_model_stock1", m_stock[4], 2);
    coin_log.delete();
    txn(3, 1, -1);
    check_log("t3", '{4, 4});
    chk("t3_remain", remain, 1);

    // Test 5: abort together with the first ack, change 15
    coin_log.delete();
    txn(15, 2, 4);
    check_log("t5", '{2});
    chk("t5_remain", remain, 5);

    // Test 6: reset while coin_req is high
    start = 1; change_amt = 8'd30; m_abort = 0;
    tick(-1, -1);
    exp_busy = 1; exp_remain = 30; m_remain = 30;
    pick = greedy(30);
    tick(-1, -1);
    exp_req = 1; exp_sel = pick;
    #2;
    check_en = 0;
    sys_rst_n = 0;
    #1;
    chk("t6_async_req", coin_req, 0);
    chk("t6_async_busy", busy, 0);
    model_reset();
    @(posedge sys_clk); @(posedge sys_clk); #1;
    sys_rst_n = 1; check_en = 1;
    tick(-1, -1);

    // Test 4: never ack, change 50
    coin_log.delete();
    txn(50, -2, -1);
    check_log("t4", '{0});
    chk("t4_req_cycles", last_req_run, 16);
    chk("t4_remain", remain, 50);
    chk("t4_model_stock50", m_stock[0], 0);
    coin_log.delete();
    txn(50, 0, -1);
    check_log("t4b", '{1, 1, 2});

    // Randomized traffic with refills, aborts, jams and stray starts
    rand_en = 1;
    repeat (150) begin
      int amt, ac;
      amt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 10)) : int'($urandom_range(0, 255));
      ac  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 30)) : -1;
      txn(amt, -1, ac);
      repeat ($urandom_range(0, 2)) tick(-1, -1);
    end
    rand_en = 0;
    tick(-1, -1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #3_000_000;
    n_errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
